lsu_dccm_arb: RTL and testbench

- Arbitrates the single DCCM port among three requesters:
  - the LSU pipe load in dc1;
  - the DMA slave;
  - the store-buffer drain.
- Pipe loads have fixed priority. DMA and stbuf share the remaining slots round-robin.
- Starvation counters raise a registered pipe-stall request so decode holds off and a waiting requester gets the port.
- Sits beside the LSU clock-domain block and supplies an activity indication used for its free-clock enable.

---
 rtl/lsu_dccm_arb_if.sv | 36 +++
 rtl/lsu_dccm_arb.sv | 109 ++++++++++
 tb/tb_lsu_dccm_arb.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lsu_dccm_arb_if.sv
//------------------------------------------------------------------------------
// Module   : lsu_dccm_arb_if
// Brief    : Request/grant/strobe bundle between DCCM requesters and the arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lsu_dccm_arb_if ();
    logic lsu_freeze;
    logic pipe_req;
    logic dma_req;
    logic dma_write;
    logic stbuf_req;
    logic stbuf_full;
    logic pipe_gnt;
    logic dma_gnt;
    logic stbuf_gnt;
    logic dccm_rd_en;
    logic dccm_wr_en;
    logic pipe_stall_req;
    logic arb_active;

    modport master (
        output lsu_freeze, pipe_req, dma_req, dma_write, stbuf_req, stbuf_full,
        input  pipe_gnt, dma_gnt, stbuf_gnt, dccm_rd_en, dccm_wr_en,
               pipe_stall_req, arb_active
    );

    modport slave (
        input  lsu_freeze, pipe_req, dma_req, dma_write, stbuf_req, stbuf_full,
        output pipe_gnt, dma_gnt, stbuf_gnt, dccm_rd_en, dccm_wr_en,
               pipe_stall_req, arb_active
    );
endinterface

`default_nettype wire

// File: rtl/lsu_dccm_arb.sv
//------------------------------------------------------------------------------
// Module   : lsu_dccm_arb
// Brief    : DCCM port arbiter: fixed-priority pipe loads, round-robin DMA/stbuf,
//            starvation-driven pipe stall request.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_dccm_arb #(
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lsu_dccm_arb_if.slave      bus
);

    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] c_starve_thr = CNT_W'(STARVE_MAX - 1);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

    generate
        if (STARVE_MAX < 2 || STARVE_MAX > (2**CNT_W) - 1) begin : g_param_check
            $error("lsu_dccm_arb: STARVE_MAX out of range for CNT_W");
        end
    endgenerate

    logic             r_rr_ptr;
    logic [CNT_W-1:0] r_dma_wait_cnt;
    logic [CNT_W-1:0] r_stbuf_wait_cnt;
    logic             r_stall;

    logic w_pipe_win;
    logic w_pipe_gnt;
    logic w_dma_gnt;
    logic w_stbuf_gnt;
    logic w_stall_d;

    assign w_pipe_win = bus.pipe_req & ~bus.lsu_freeze;
    // Grants are forced low combinationally while reset is held.
    assign w_pipe_gnt = w_pipe_win & ~rst;

    always_comb begin
        w_dma_gnt   = 1'b0;
        w_stbuf_gnt = 1'b0;
        if (!rst && !w_pipe_win) begin
            if (bus.stbuf_req && bus.stbuf_full) begin
                w_stbuf_gnt = 1'b1;
            end else if (bus.dma_req && bus.stbuf_req) begin
                w_stbuf_gnt = r_rr_ptr;
                w_dma_gnt   = ~r_rr_ptr;
            end else if (bus.dma_req) begin
                w_dma_gnt = 1'b1;
            end else if (bus.stbuf_req) begin
                w_stbuf_gnt = 1'b1;
            end
        end
    end

    assign w_stall_d = (bus.dma_req   & ~w_dma_gnt   & (r_dma_wait_cnt   >= c_starve_thr))
                     | (bus.stbuf_req & ~w_stbuf_gnt & (r_stbuf_wait_cnt >= c_starve_thr))
                     | (bus.stbuf_req & bus.stbuf_full & ~w_stbuf_gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr         <= 1'b0;
            r_dma_wait_cnt   <= '0;
            r_stbuf_wait_cnt <= '0;
            r_stall          <= 1'b0;
        end else begin
            if (w_dma_gnt) begin
                r_rr_ptr <= 1'b1;
            end else if (w_stbuf_gnt) begin
                r_rr_ptr <= 1'b0;
            end

            // Counters saturate so a long wait cannot wrap back under threshold.
            if (bus.dma_req && !w_dma_gnt) begin
                if (r_dma_wait_cnt != c_starve_max) begin
                    r_dma_wait_cnt <= r_dma_wait_cnt + c_one;
                end
            end else begin
                r_dma_wait_cnt <= '0;
            end

            if (bus.stbuf_req && !w_stbuf_gnt) begin
                if (r_stbuf_wait_cnt != c_starve_max) begin
                    r_stbuf_wait_cnt <= r_stbuf_wait_cnt + c_one;
                end
            end else begin
                r_stbuf_wait_cnt <= '0;
            end

            r_stall <= w_stall_d;
        end
    end

    assign bus.pipe_gnt       = w_pipe_gnt;
    assign bus.dma_gnt        = w_dma_gnt;
    assign bus.stbuf_gnt      = w_stbuf_gnt;
    assign bus.dccm_rd_en     = w_pipe_gnt | (w_dma_gnt & ~bus.dma_write);
    assign bus.dccm_wr_en     = w_stbuf_gnt | (w_dma_gnt & bus.dma_write);
    assign bus.pipe_stall_req = r_stall;
    assign bus.arb_active     = bus.pipe_req | bus.dma_req | bus.stbuf_req | r_stall
                              | (r_dma_wait_cnt != '0) | (r_stbuf_wait_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_lsu_dccm_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_lsu_dccm_arb
// Brief    : Directed vector table plus hand-written sequences for lsu_dccm_arb.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_dccm_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_dccm_arb_if bus ();

    lsu_dccm_arb #(
        .STARVE_MAX (8),
        .CNT_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // in  = {lsu_freeze, pipe_req, dma_req, dma_write, stbuf_req, stbuf_full}
    // exp = {pipe_gnt, dma_gnt, stbuf_gnt, dccm_rd_en, dccm_wr_en, pipe_stall_req, arb_active}
    typedef struct {
        logic [5:0] in;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [6:0] outs();
        return {bus.pipe_gnt, bus.dma_gnt, bus.stbuf_gnt, bus.dccm_rd_en,
                bus.dccm_wr_en, bus.pipe_stall_req, bus.arb_active};
    endfunction

    task automatic set_in(input logic [5:0] in);
        {bus.lsu_freeze, bus.pipe_req, bus.dma_req, bus.dma_write,
         bus.stbuf_req, bus.stbuf_full} = in;
    endtask

    task automatic apply(input logic [5:0] in);
        @(posedge clk);
        #1;
        set_in(in);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(6'b000000);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{in: 6'b000000, exp: 7'b0000000, name: "reset_idle"};
        vecs[1]  = '{in: 6'b001010, exp: 7'b0101001, name: "rr_dma_1"};
        vecs[2]  = '{in: 6'b001010, exp: 7'b0010101, name: "rr_stbuf_1"};
        vecs[3]  = '{in: 6'b001010, exp: 7'b0101001, name: "rr_dma_2"};
        vecs[4]  = '{in: 6'b001010, exp: 7'b0010101, name: "rr_stbuf_2"};
        vecs[5]  = '{in: 6'b111100, exp: 7'b0100101, name: "freeze_dma_wr"};
        vecs[6]  = '{in: 6'b000010, exp: 7'b0010101, name: "stbuf_only"};
        vecs[7]  = '{in: 6'b001011, exp: 7'b0010101, name: "full_beats_rr"};
        vecs[8]  = '{in: 6'b000000, exp: 7'b0000001, name: "full_no_stall"};
        vecs[9]  = '{in: 6'b011011, exp: 7'b1001001, name: "full_vs_pipe"};
        vecs[10] = '{in: 6'b000000, exp: 7'b0000011, name: "full_stall"};
        vecs[11] = '{in: 6'b000000, exp: 7'b0000000, name: "stall_clear"};
        vecs[12] = '{in: 6'b000100, exp: 7'b0000000, name: "write_no_req"};

        set_in(6'b000000);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].in);
            check(vecs[i].name, outs(), vecs[i].exp);
        end

        // DMA starves behind pipe loads; stall rises after 8 waiting cycles.
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            apply(6'b011000);
            check($sformatf("starve_c%0d", c), outs(),
                  {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (c == 9), 1'b1});
        end
        apply(6'b001000);
        check("starve_dma_gnt", outs(), 7'b0101011);
        apply(6'b000000);
        check("starve_release", outs(), 7'b0000000);

        // Build rr_ptr=1, wait count and stall, then reset mid-cycle.
        do_reset();
        apply(6'b001000);
        check("ar_dma_first", outs(), 7'b0101001);
        for (int k = 0; k < 5; k++) begin
            apply(6'b011011);
            check($sformatf("ar_build_%0d", k), outs(),
                  {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (k > 0), 1'b1});
        end
        apply(6'b001010);
        check("ar_rr_stbuf", outs(), 7'b0010111);
        #2;
        rst = 1'b1;
        #1;
        check("ar_async_clear", {outs()[6:1], 1'b0}, 7'b0000000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ar_dma_preferred", outs(), 7'b0101001);

        apply(6'b000000);
        check("idle_1", outs(), 7'b0000001);
        apply(6'b000000);
        check("idle_2", outs(), 7'b0000000);
        apply(6'b000000);
        check("idle_3", outs(), 7'b0000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
